// File: rtl/cache_ctrl_2way_param.sv
// 2-way set-associative write-through, no-write-allocate cache controller with
// invalid-first/LRU replacement, single-cycle flush and saturating hit/miss counters.
module cache_ctrl_2way_param #(
    parameter int ADDR_W         = 16,
    parameter int DATA_W         = 32,
    parameter int WORDS_PER_LINE = 2,
    parameter int SETS           = 64,
    parameter int CNT_W          = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [ADDR_W-1:0]                address,
    input  logic [DATA_W-1:0]                wdata,
    input  logic                             mem_read,
    input  logic                             mem_write,
    input  logic                             flush,
    output logic [DATA_W-1:0]                rdata,
    output logic                             freeze,
    output logic                             sram_read,
    output logic                             sram_write,
    output logic [ADDR_W-1:0]                sram_addr,
    output logic [DATA_W-1:0]                sram_wdata,
    input  logic [DATA_W*WORDS_PER_LINE-1:0] sram_rdata,
    input  logic                             sram_ready,
    output logic [CNT_W-1:0]                 hit_cnt,
    output logic [CNT_W-1:0]                 miss_cnt
);

    localparam int OFF_W = $clog2(WORDS_PER_LINE);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDR_W - IDX_W - OFF_W;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_MISS = 2'd1,
        WR_THRU = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [1:0][SETS-1:0]   valid_q, valid_d;
    logic [SETS-1:0]        lru_q, lru_d;
    logic                   sram_read_q, sram_write_q;
    logic [ADDR_W-1:0]      sram_addr_q, sram_addr_d;
    logic [DATA_W-1:0]      sram_wdata_q, sram_wdata_d;
    logic [CNT_W-1:0]       hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0]       miss_cnt_q, miss_cnt_d;

    // Tag and data storage carry no reset; the valid bits qualify them.
    logic [TAG_W-1:0]       tag_mem  [2][SETS];
    logic [DATA_W-1:0]      data_mem [2][SETS][WORDS_PER_LINE];

    logic [TAG_W-1:0]       a_tag;
    logic [IDX_W-1:0]       a_idx;
    logic [OFF_W-1:0]       a_off;
    logic                   hit0, hit1, hit, hit_way, victim;
    logic [DATA_W-1:0]      hit_word;
    logic                   wr_word_en, fill_en;

    assign a_tag = address[ADDR_W-1 -: TAG_W];
    assign a_idx = address[OFF_W +: IDX_W];
    assign a_off = address[OFF_W-1:0];

    assign hit0     = valid_q[0][a_idx] && (tag_mem[0][a_idx] == a_tag);
    assign hit1     = valid_q[1][a_idx] && (tag_mem[1][a_idx] == a_tag);
    assign hit      = hit0 | hit1;
    assign hit_way  = hit1;
    assign hit_word = data_mem[hit_way][a_idx][a_off];
    assign victim   = !valid_q[0][a_idx] ? 1'b0 :
                      !valid_q[1][a_idx] ? 1'b1 : lru_q[a_idx];

    always_comb begin
        state_d      = state_q;
        valid_d      = valid_q;
        lru_d        = lru_q;
        sram_addr_d  = sram_addr_q;
        sram_wdata_d = sram_wdata_q;
        hit_cnt_d    = hit_cnt_q;
        miss_cnt_d   = miss_cnt_q;
        freeze       = 1'b0;
        rdata        = '0;
        wr_word_en   = 1'b0;
        fill_en      = 1'b0;
        case (state_q)
            IDLE: begin
                if (flush) begin
                    valid_d = '0;
                    lru_d   = '0;
                    freeze  = mem_read | mem_write;
                end else if (mem_write) begin
                    freeze       = 1'b1;
                    sram_addr_d  = address;
                    sram_wdata_d = wdata;
                    state_d      = WR_THRU;
                    if (hit) begin
                        wr_word_en   = 1'b1;
                        lru_d[a_idx] = ~hit_way;
                    end
                end else if (mem_read) begin
                    if (hit) begin
                        rdata        = hit_word;
                        lru_d[a_idx] = ~hit_way;
                        if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + 1'b1;
                    end else begin
                        freeze      = 1'b1;
                        sram_addr_d = {address[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                        state_d     = RD_MISS;
                        if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + 1'b1;
                    end
                end
            end
            RD_MISS: begin
                freeze = ~sram_ready;
                if (sram_ready) begin
                    rdata                  = sram_rdata[a_off*DATA_W +: DATA_W];
                    fill_en                = 1'b1;
                    valid_d[victim][a_idx] = 1'b1;
                    lru_d[a_idx]           = ~victim;
                    state_d                = IDLE;
                end
            end
            WR_THRU: begin
                freeze = ~sram_ready;
                if (sram_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Strobes are registered from the next state so they track state_q exactly.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            valid_q      <= '0;
            lru_q        <= '0;
            sram_read_q  <= 1'b0;
            sram_write_q <= 1'b0;
            sram_addr_q  <= '0;
            sram_wdata_q <= '0;
            hit_cnt_q    <= '0;
            miss_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            valid_q      <= valid_d;
            lru_q        <= lru_d;
            sram_read_q  <= (state_d == RD_MISS);
            sram_write_q <= (state_d == WR_THRU);
            sram_addr_q  <= sram_addr_d;
            sram_wdata_q <= sram_wdata_d;
            hit_cnt_q    <= hit_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
        end
    end

    // Gated by rst so nothing lands in the arrays while reset is asserted.
    always_ff @(posedge clk) begin
        if (rst && wr_word_en) begin
            data_mem[hit_way][a_idx][a_off] <= wdata;
        end
        if (rst && fill_en) begin
            tag_mem[victim][a_idx] <= a_tag;
            for (int w = 0; w < WORDS_PER_LINE; w++) begin
                data_mem[victim][a_idx][w] <= sram_rdata[w*DATA_W +: DATA_W];
            end
        end
    end

    assign sram_read  = sram_read_q;
    assign sram_write = sram_write_q;
    assign sram_addr  = sram_addr_q;
    assign sram_wdata = sram_wdata_q;
    assign hit_cnt    = hit_cnt_q;
    assign miss_cnt   = miss_cnt_q;

endmodule
